// File: rtl/db_cache_pkg.sv
// +----------------------------------------------------------------------+
// | db_cache_pkg: bus access encodings, FSM states and defaults          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package db_cache_pkg;

  localparam int MEM_ACCESS_WIDTH = 2;
  typedef logic [MEM_ACCESS_WIDTH-1:0] mem_access_t;

  localparam mem_access_t MEM_ACCESS_NONE = 2'd0;
  localparam mem_access_t MEM_ACCESS_R    = 2'd1;
  localparam mem_access_t MEM_ACCESS_W    = 2'd2;
  localparam mem_access_t MEM_ACCESS_X    = 2'd3;

  localparam int CACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEM_READ  = 2'd1,
    S_MEM_WRITE = 2'd2
  } state_e;

  function automatic logic is_read(input mem_access_t t);
    return (t == MEM_ACCESS_R) || (t == MEM_ACCESS_X);
  endfunction

endpackage

`default_nettype wire

// File: rtl/db_cache_line_array.sv
// +----------------------------------------------------------------------+
// | db_cache_line_array: valid/tag/data storage, async lookup, 1 write   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module db_cache_line_array
  import db_cache_pkg::*;
#(
  parameter int INDEX_BITS = CACHE_INDEX_BITS
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    flush_i,
  input  logic [INDEX_BITS-1:0]   rd_index_i,
  output logic                    rd_valid_o,
  output logic [29-INDEX_BITS:0]  rd_tag_o,
  output logic [31:0]             rd_data_o,
  input  logic                    we_i,
  input  logic [INDEX_BITS-1:0]   wr_index_i,
  input  logic [29-INDEX_BITS:0]  wr_tag_i,
  input  logic [31:0]             wr_data_i
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]          valid_q;
  logic [29-INDEX_BITS:0]    tag_q  [DEPTH];
  logic [31:0]               data_q [DEPTH];

  // Only the valid bits need clearing; stale tag/data are masked by them.
  always_ff @(posedge clk) begin
    if (!res || flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

`default_nettype wire

// File: rtl/db_cache.sv
// +----------------------------------------------------------------------+
// | db_cache: direct-mapped write-through one-word-line data-bus cache   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module db_cache
  import db_cache_pkg::*;
#(
  parameter int    INDEX_BITS = CACHE_INDEX_BITS,
  parameter string TAG        = "db_cache"
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] db_addr,
  input  logic [31:0] db_dataIn,
  output logic [31:0] db_dataOut,
  input  mem_access_t db_accessType,
  input  logic        db_io,
  input  logic        cachable,
  output logic        db_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataOut,
  input  logic [31:0] mem_dataIn,
  output mem_access_t mem_accessType,
  input  logic        mem_ready,
  input  logic        flush,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  state_e        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  mem_access_t   type_q;
  logic          cacheok_q;
  logic [31:0]   hit_cnt_q;
  logic [31:0]   miss_cnt_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  cache_ok;
  logic                  req;
  logic                  rd_req;
  logic                  hit;
  logic                  arr_we;
  logic [31:0]           arr_wdata;
  logic                  unused_addr_bits;

  assign idx              = db_addr[INDEX_BITS+1:2];
  assign tag              = db_addr[31:INDEX_BITS+2];
  assign unused_addr_bits = ^db_addr[1:0];
  assign cache_ok         = cachable && !db_io;
  assign req              = (db_accessType != MEM_ACCESS_NONE);
  assign rd_req           = is_read(db_accessType);
  assign hit              = cache_ok && rd_valid && (rd_tag == tag);

  db_cache_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_lines (
    .clk        (clk),
    .res        (res),
    .flush_i    (flush && (state_q == S_IDLE)),
    .rd_index_i (idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (arr_we),
    .wr_index_i (addr_q[INDEX_BITS+1:2]),
    .wr_tag_i   (addr_q[31:INDEX_BITS+2]),
    .wr_data_i  (arr_wdata)
  );

  // Completion is gated by the live request so a withdrawn access is not acked,
  // while the memory transaction and array update still finish.
  always_comb begin
    db_ready       = 1'b0;
    db_dataOut     = rd_data;
    mem_accessType = MEM_ACCESS_NONE;
    arr_we         = 1'b0;
    arr_wdata      = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        db_ready = rd_req && !flush && hit;
      end
      S_MEM_READ: begin
        mem_accessType = type_q;
        if (mem_ready) begin
          db_ready   = req;
          db_dataOut = mem_dataIn;
          arr_we     = cacheok_q;
          arr_wdata  = mem_dataIn;
        end
      end
      S_MEM_WRITE: begin
        mem_accessType = MEM_ACCESS_W;
        if (mem_ready) begin
          db_ready = req;
          arr_we   = cacheok_q;
        end
      end
      default: ;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_dataOut = wdata_q;
  assign hitCount    = hit_cnt_q;
  assign missCount   = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= MEM_ACCESS_NONE;
      cacheok_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req && !flush) begin
            if (rd_req && hit) begin
              hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
              addr_q    <= db_addr;
              wdata_q   <= db_dataIn;
              type_q    <= db_accessType;
              cacheok_q <= cache_ok;
              state_q   <= rd_req ? S_MEM_READ : S_MEM_WRITE;
              if (rd_req && cache_ok) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
              end
            end
          end
        end
        S_MEM_READ, S_MEM_WRITE: begin
          if (mem_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res && (state_q == S_MEM_READ)) begin
      assert (is_read(type_q))
        else $error("%s: latched read type %0d is not R/X", TAG, type_q);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_db_cache.sv
// +----------------------------------------------------------------------+
// | tb_db_cache: directed self-checking bench for db_cache               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_db_cache;
  import db_cache_pkg::*;

  logic        clk;
  logic        res;
  logic [31:0] db_addr;
  logic [31:0] db_dataIn;
  logic [31:0] db_dataOut;
  mem_access_t db_accessType;
  logic        db_io;
  logic        cachable;
  logic        db_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataOut;
  logic [31:0] mem_dataIn;
  mem_access_t mem_accessType;
  logic        mem_ready;
  logic        flush;
  logic [31:0] hitCount;
  logic [31:0] missCount;

  int          n_total;
  int          n_pass;

  logic [31:0] r_data;
  int          r_cycles;
  logic        r_sawmem;
  mem_access_t r_mtype;
  logic [31:0] r_maddr;
  logic [31:0] r_mdout;

  db_cache u_dut (
    .clk            (clk),
    .res            (res),
    .db_addr        (db_addr),
    .db_dataIn      (db_dataIn),
    .db_dataOut     (db_dataOut),
    .db_accessType  (db_accessType),
    .db_io          (db_io),
    .cachable       (cachable),
    .db_ready       (db_ready),
    .mem_addr       (mem_addr),
    .mem_dataOut    (mem_dataOut),
    .mem_dataIn     (mem_dataIn),
    .mem_accessType (mem_accessType),
    .mem_ready      (mem_ready),
    .flush          (flush),
    .hitCount       (hitCount),
    .missCount      (missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Starts at posedge+1, ends at posedge+1 after db_ready; memory answers
  // lat cycles after it first sees a request.
  task automatic access(input mem_access_t typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic io, input logic cach,
                        input int lat, input logic [31:0] mdata);
    int   memc;
    logic done;
    db_accessType = typ;
    db_addr       = addr;
    db_dataIn     = wdata;
    db_io         = io;
    cachable      = cach;
    mem_ready     = 1'b0;
    memc          = 0;
    done          = 1'b0;
    r_cycles      = 0;
    r_sawmem      = 1'b0;
    r_data        = 32'hx;
    while (!done && r_cycles < 50) begin
      @(negedge clk);
      if (db_ready) begin
        r_data = db_dataOut;
        done   = 1'b1;
      end
      if (mem_accessType != MEM_ACCESS_NONE) begin
        r_sawmem = 1'b1;
        r_mtype  = mem_accessType;
        r_maddr  = mem_addr;
        r_mdout  = mem_dataOut;
      end
      @(posedge clk);
      #1;
      r_cycles++;
      if (done) begin
        db_accessType = MEM_ACCESS_NONE;
        mem_ready     = 1'b0;
      end else if (mem_accessType != MEM_ACCESS_NONE) begin
        memc++;
        mem_ready  = (memc == lat);
        mem_dataIn = mdata;
      end
    end
    check("access_done", {31'd0, done}, 32'd1);
    db_io    = 1'b0;
    cachable = 1'b1;
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    res           = 1'b0;
    flush         = 1'b0;
    db_accessType = MEM_ACCESS_NONE;
    db_addr       = '0;
    db_dataIn     = '0;
    db_io         = 1'b0;
    cachable      = 1'b1;
    mem_dataIn    = '0;
    mem_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    @(negedge clk);
    check("rst_ready",   {31'd0, db_ready}, 32'd0);
    check("rst_memtype", {30'd0, mem_accessType}, 32'd0);
    check("rst_hits",    hitCount, 32'd0);
    check("rst_misses",  missCount, 32'd0);
    @(posedge clk);
    #1;

    // Cold miss
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 3, 32'hDEAD_BEEF);
    check("miss_data",  r_data, 32'hDEAD_BEEF);
    check("miss_lat",   r_cycles, 32'd4);
    check("miss_maddr", r_maddr, 32'h0000_0100);
    check("miss_mtype", {30'd0, r_mtype}, {30'd0, MEM_ACCESS_R});
    check("miss_cnt1",  missCount, 32'd1);

    // Hit
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 3, 32'h0BAD_0BAD);
    check("hit_data",  r_data, 32'hDEAD_BEEF);
    check("hit_lat",   r_cycles, 32'd1);
    check("hit_nomem", {31'd0, r_sawmem}, 32'd0);
    check("hit_cnt1",  hitCount, 32'd1);

    // Write-through with allocate, then back-to-back read hit
    access(MEM_ACCESS_W, 32'h0000_0100, 32'h1234_5678, 1'b0, 1'b1, 2, 32'h0);
    check("wr_lat",   r_cycles, 32'd3);
    check("wr_mtype", {30'd0, r_mtype}, {30'd0, MEM_ACCESS_W});
    check("wr_mdout", r_mdout, 32'h1234_5678);
    check("wr_maddr", r_maddr, 32'h0000_0100);
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 2, 32'h0);
    check("rdw_data", r_data, 32'h1234_5678);
    check("rdw_lat",  r_cycles, 32'd1);
    check("hit_cnt2", hitCount, 32'd2);
    check("miss_cnt_wr", missCount, 32'd1);

    // IO read and uncachable write bypass without touching the array
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 2, 32'hCAFE_F00D);
    check("io_data",  r_data, 32'hCAFE_F00D);
    check("io_mem",   {31'd0, r_sawmem}, 32'd1);
    check("io_miss",  missCount, 32'd1);
    access(MEM_ACCESS_W, 32'h0000_0100, 32'hAAAA_5555, 1'b0, 1'b0, 1, 32'h0);
    check("nc_wr_mdout", r_mdout, 32'hAAAA_5555);
    access(MEM_ACCESS_X, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 2, 32'h0);
    check("stale_data",  r_data, 32'h1234_5678);
    check("stale_nomem", {31'd0, r_sawmem}, 32'd0);
    check("hit_cnt3",    hitCount, 32'd3);

    // Index conflict: 0x200 shares index 0 with 0x100
    access(MEM_ACCESS_R, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 1, 32'h2222_2222);
    check("cf1_data", r_data, 32'h2222_2222);
    check("cf1_lat",  r_cycles, 32'd2);
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1, 32'h1111_1111);
    check("cf2_data", r_data, 32'h1111_1111);
    check("cf2_mem",  {31'd0, r_sawmem}, 32'd1);
    check("miss_cnt3", missCount, 32'd3);
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1, 32'h0);
    check("cf3_data", r_data, 32'h1111_1111);
    check("hit_cnt4", hitCount, 32'd4);

    // Flush coinciding with a request takes priority
    flush         = 1'b1;
    db_accessType = MEM_ACCESS_R;
    db_addr       = 32'h0000_0100;
    @(negedge clk);
    check("flush_noready", {31'd0, db_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    access(MEM_ACCESS_R, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1, 32'h3333_3333);
    check("flush_data", r_data, 32'h3333_3333);
    check("flush_lat",  r_cycles, 32'd2);
    check("miss_cnt4",  missCount, 32'd4);
    check("hit_cnt_fl", hitCount, 32'd4);

    // Reset in the middle of a miss
    db_accessType = MEM_ACCESS_R;
    db_addr       = 32'h0000_0300;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_mtype", {30'd0, mem_accessType}, {30'd0, MEM_ACCESS_R});
    check("miss_cnt5", missCount, 32'd5);
    @(posedge clk);
    #1;
    res           = 1'b0;
    db_accessType = MEM_ACCESS_NONE;
    @(posedge clk);
    #1;
    res = 1'b1;
    @(negedge clk);
    check("rst2_mtype",  {30'd0, mem_accessType}, 32'd0);
    check("rst2_ready",  {31'd0, db_ready}, 32'd0);
    check("rst2_hits",   hitCount, 32'd0);
    check("rst2_misses", missCount, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
